arb_mux: RTL and testbench

- Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output.
- The select is generated internally: round-robin by default, fixed-priority optionally.
- The result is registered in a single output stage that holds under backpressure.
- Used wherever several datapath producers share one consumer, e.g. writeback/result bus sharing between ALU, multiplier and load unit.

---
 rtl/arb_mux.sv | 109 ++++++++++
 tb/tb_arb_mux.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux
// Description : N-channel valid/ready multiplexer with an internal round-robin
//               or fixed-priority arbiter and one registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 32,
  parameter int RR_MODE = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_CH-1:0]                             in_valid,
  input  logic [NUM_CH*WIDTH-1:0]                       in_data,
  output logic [NUM_CH-1:0]                             in_ready,
  output logic                                          out_valid,
  output logic [WIDTH-1:0]                              out_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  input  logic                                          out_ready
);

  localparam int                c_ch_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [c_ch_w-1:0] c_last = c_ch_w'(NUM_CH - 1);

  logic [c_ch_w-1:0] r_ptr;
  logic [c_ch_w-1:0] w_base;
  logic [c_ch_w-1:0] w_lo_idx;
  logic [c_ch_w-1:0] w_hi_idx;
  logic [c_ch_w-1:0] w_grant_idx;
  logic              w_lo_any;
  logic              w_hi_any;
  logic              w_any;
  logic              w_load_en;
  logic              w_xfer;
  logic [NUM_CH-1:0] w_grant_oh;
  logic [WIDTH-1:0]  w_sel_data;

  assign w_load_en = !out_valid || out_ready;
  assign w_base    = (RR_MODE != 0) ? r_ptr : '0;

  // Two priority searches: lowest requester at or above the pointer wins,
  // otherwise the search wraps to the lowest requester overall.
  always_comb begin
    w_lo_idx = '0;
    w_lo_any = 1'b0;
    w_hi_idx = '0;
    w_hi_any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_lo_idx = c_ch_w'(i);
        w_lo_any = 1'b1;
        if (c_ch_w'(i) >= w_base) begin
          w_hi_idx = c_ch_w'(i);
          w_hi_any = 1'b1;
        end
      end
    end
  end

  assign w_any       = w_lo_any;
  assign w_grant_idx = w_hi_any ? w_hi_idx : w_lo_idx;
  assign w_xfer      = w_any && w_load_en;

  always_comb begin
    w_grant_oh = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_any && (w_grant_idx == c_ch_w'(i))) begin
        w_grant_oh[i] = 1'b1;
        w_sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reset gating keeps producers from seeing an accept while held in reset.
  assign in_ready = (rst_n && w_load_en) ? w_grant_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (w_load_en) begin
      out_valid <= w_any;
      if (w_any) begin
        out_data <= w_sel_data;
        out_ch   <= w_grant_idx;
      end
    end
  end

  generate
    if ((RR_MODE != 0) && (NUM_CH > 1)) begin : g_rr_ptr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= '0;
        end else if (w_xfer) begin
          r_ptr <= (w_grant_idx == c_last) ? '0 : w_grant_idx + 1'b1;
        end
      end
    end else begin : g_no_ptr
      assign r_ptr = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_mux
// Description : Self-checking bench for arb_mux (round-robin and fixed-priority).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [1:0]   ch;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] d [N];
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid, in_ready, fp_in_valid, fp_in_ready;
  logic         out_valid, out_ready, fp_out_valid, fp_out_ready;
  logic [W-1:0] out_data, fp_out_data;
  logic [1:0]   out_ch, fp_out_ch;

  int   checks = 0;
  int   failures = 0;
  int   m_ptr;
  logic m_ov;
  exp_t sb[$];

  always #5 clk = ~clk;
  assign in_data = {d[3], d[2], d[1], d[0]};

  arb_mux #(.NUM_CH(N), .WIDTH(W), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready)
  );

  arb_mux #(.NUM_CH(N), .WIDTH(W), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(fp_in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_ch(fp_out_ch), .out_ready(fp_out_ready)
  );

  // Round-robin reference: first requester from p upward, wrapping.
  function automatic int exp_grant(input logic [N-1:0] v, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = exp_grant(in_valid, m_ptr);
    if ((!m_ov || out_ready) && g >= 0) r[g[1:0]] = 1'b1;
    return r;
  endfunction

  task automatic m_reset();
    m_ptr = 0;
    m_ov  = 1'b0;
    sb.delete();
  endtask

  // Updates the reference model for the coming edge, then steps one cycle.
  task automatic advance();
    int   g;
    logic load;
    exp_t e;
    g    = exp_grant(in_valid, m_ptr);
    load = !m_ov || out_ready;
    if (m_ov && out_ready) void'(sb.pop_front());
    if (load) begin
      if (g >= 0) begin
        e.ch   = 2'(g);
        e.data = d[g[1:0]];
        sb.push_back(e);
        m_ov  = 1'b1;
        m_ptr = (g + 1) % N;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    in_valid     = '0;
    fp_in_valid  = '0;
    out_ready    = 1'b1;
    fp_out_ready = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    m_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_data !== '0 || out_ch !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b ready=%b data=%h ch=%0d exp 0/0000/0/0", out_valid, in_ready, out_data, out_ch);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant: got %b exp 0001", in_ready);
    end
    advance();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 32'hA0) begin
      failures++;
      $display("FAIL reset_first_word: valid=%b ch=%0d data=%h exp 1/0/a0", out_valid, out_ch, out_data);
    end
    in_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    in_valid = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== m_ov) begin
        failures++;
        $display("FAIL rr_valid: cyc %0d got %b exp %b", c, out_valid, m_ov);
      end
      if (m_ov) begin
        checks++;
        if (out_ch !== sb[0].ch || out_data !== sb[0].data) begin
          failures++;
          $display("FAIL rr_word: cyc %0d got ch%0d %h exp ch%0d %h", c, out_ch, out_data, sb[0].ch, sb[0].data);
        end
      end
      checks++;
      if (in_ready !== exp_ready()) begin
        failures++;
        $display("FAIL rr_ready: cyc %0d got %b exp %b", c, in_ready, exp_ready());
      end
      if (c >= 1) begin
        checks++;
        if (out_ch !== 2'((c - 1) % N) || out_data !== 32'hA0 + 32'((c - 1) % N)) begin
          failures++;
          $display("FAIL rr_sequence: cyc %0d got ch%0d exp ch%0d", c, out_ch, (c - 1) % N);
        end
      end
      advance();
    end
    in_valid = '0;
  endtask

  task automatic test_sparse_wrap();
    logic [N-1:0] vt [6] = '{4'b0100, 4'b0011, 4'b0010, 4'b1111, 4'b0000, 4'b0000};
    logic [N-1:0] rt [6] = '{4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      in_valid = vt[c];
      @(negedge clk);
      checks++;
      if (in_ready !== rt[c]) begin
        failures++;
        $display("FAIL sparse_grant: step %0d got %b exp %b", c, in_ready, rt[c]);
      end
      checks++;
      if (out_valid !== m_ov) begin
        failures++;
        $display("FAIL sparse_valid: step %0d got %b exp %b", c, out_valid, m_ov);
      end
      if (m_ov) begin
        checks++;
        if (out_ch !== sb[0].ch || out_data !== sb[0].data) begin
          failures++;
          $display("FAIL sparse_word: step %0d got ch%0d %h exp ch%0d %h", c, out_ch, out_data, sb[0].ch, sb[0].data);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    d[0]     = 32'hDEADBEEF;
    in_valid = 4'b1111;
    advance();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold: cyc %0d valid=%b data=%h ch=%0d ready=%b exp 1/deadbeef/0/0000", c, out_valid, out_data, out_ch, in_ready);
      end
      checks++;
      if (in_ready !== exp_ready() || out_data !== sb[0].data) begin
        failures++;
        $display("FAIL bp_model: cyc %0d ready=%b exp %b", c, in_ready, exp_ready());
      end
      advance();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_release_grant: got %b exp 0010", in_ready);
    end
    advance();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 32'hA1) begin
      failures++;
      $display("FAIL bp_no_bubble: valid=%b ch=%0d data=%h exp 1/1/a1", out_valid, out_ch, out_data);
    end
    d[0]     = 32'hA0;
    in_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    advance();
    advance();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre_valid: got %b exp 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL arst_immediate: valid=%b ready=%b exp 0/0000", out_valid, in_ready);
    end
    m_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0001 || in_ready !== exp_ready()) begin
      failures++;
      $display("FAIL arst_restart: got %b exp 0001", in_ready);
    end
    advance();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 32'hA0) begin
      failures++;
      $display("FAIL arst_first_word: valid=%b ch=%0d data=%h exp 1/0/a0", out_valid, out_ch, out_data);
    end
    in_valid = '0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    fp_in_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (fp_in_ready !== 4'b0010) begin
        failures++;
        $display("FAIL fp_grant: cyc %0d got %b exp 0010", c, fp_in_ready);
      end
      if (c >= 1) begin
        checks++;
        if (fp_out_valid !== 1'b1 || fp_out_ch !== 2'd1 || fp_out_data !== 32'hA1) begin
          failures++;
          $display("FAIL fp_word: cyc %0d valid=%b ch=%0d data=%h exp 1/1/a1", c, fp_out_valid, fp_out_ch, fp_out_data);
        end
      end
      @(posedge clk);
      #1;
    end
    fp_in_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (fp_in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL fp_drop_grant: got %b exp 1000", fp_in_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (fp_out_valid !== 1'b1 || fp_out_ch !== 2'd3 || fp_out_data !== 32'hA3) begin
      failures++;
      $display("FAIL fp_drop_word: valid=%b ch=%0d data=%h exp 1/3/a3", fp_out_valid, fp_out_ch, fp_out_data);
    end
    fp_in_valid = '0;
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = '0;
    fp_in_valid  = '0;
    out_ready    = 1'b1;
    fp_out_ready = 1'b1;
    for (int i = 0; i < N; i++) d[i] = 32'hA0 + 32'(i);
    m_reset();
    test_reset();
    test_round_robin();
    test_sparse_wrap();
    test_backpressure();
    test_async_reset();
    test_fixed_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
